// File: rtl/ysyx_24100027_idu_stage.sv
// RV32I/RV32E decode stage: valid/ready in from IFU, registered decoded bundle out to EXU.
// Flags undecodable instructions and parks the front end after an EBREAK retires.
module ysyx_24100027_idu_stage #(
    parameter int XLEN     = 32,
    parameter int NR_REG   = 32,
    parameter bit EN_ZICSR = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic            out_Regwr,
    output logic [3:0]      out_Aluctr,
    output logic [2:0]      out_Extop,
    output logic            out_AluActr,
    output logic [1:0]      out_AluBctr,
    output logic [2:0]      out_Branch,
    output logic [2:0]      out_funct3,
    output logic            out_memrd,
    output logic            out_memwr,
    output logic            out_illegal,
    output logic            out_trap,
    output logic            halted
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    localparam logic [2:0] EXT_I = 3'b000;
    localparam logic [2:0] EXT_U = 3'b001;
    localparam logic [2:0] EXT_S = 3'b010;
    localparam logic [2:0] EXT_B = 3'b011;
    localparam logic [2:0] EXT_J = 3'b100;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1101;
    localparam logic [3:0] ALU_COPYB = 4'b1111;

    localparam logic [1:0] BSEL_RS2  = 2'b00;
    localparam logic [1:0] BSEL_IMM  = 2'b01;
    localparam logic [1:0] BSEL_FOUR = 2'b10;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_JAL  = 3'b001;
    localparam logic [2:0] BR_JALR = 3'b010;
    localparam logic [2:0] BR_COND = 3'b011;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [6:0]  F7_ZERO     = 7'b0000000;
    localparam logic [6:0]  F7_ALT      = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic            regwr;
        logic [3:0]      aluctr;
        logic [2:0]      extop;
        logic            aluactr;
        logic [1:0]      alubctr;
        logic [2:0]      branch;
        logic [2:0]      funct3;
        logic            memrd;
        logic            memwr;
        logic            illegal;
        logic            trap;
    } bundle_t;

    logic [0:0] state_q, state_d;
    logic       out_valid_q, out_valid_d;
    bundle_t    bundle_q, bundle_d;

    bundle_t    dec_raw, dec;
    logic       use_rd, use_rs1, use_rs2, imm_en, ill_raw;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext;

    logic [4:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd_f, rs1_f, rs2_f;

    assign opc   = in_inst[6:2];
    assign f3    = in_inst[14:12];
    assign f7    = in_inst[31:25];
    assign rd_f  = in_inst[11:7];
    assign rs1_f = in_inst[19:15];
    assign rs2_f = in_inst[24:20];

    function automatic logic reg_ok(input logic [4:0] r);
        return ({1'b0, r} < 6'(NR_REG));
    endfunction

    // Opcode-level decode: control fields, which register fields the format uses, raw legality.
    always_comb begin
        dec_raw        = '0;
        dec_raw.pc     = in_pc;
        dec_raw.funct3 = f3;
        use_rd         = 1'b0;
        use_rs1        = 1'b0;
        use_rs2        = 1'b0;
        imm_en         = 1'b1;
        ill_raw        = 1'b0;
        case (opc)
            OPC_LUI: begin
                dec_raw.extop   = EXT_U;
                dec_raw.aluctr  = ALU_COPYB;
                dec_raw.alubctr = BSEL_IMM;
                dec_raw.regwr   = 1'b1;
                use_rd          = 1'b1;
            end
            OPC_AUIPC: begin
                dec_raw.extop   = EXT_U;
                dec_raw.aluactr = 1'b1;
                dec_raw.alubctr = BSEL_IMM;
                dec_raw.aluctr  = ALU_ADD;
                dec_raw.regwr   = 1'b1;
                use_rd          = 1'b1;
            end
            OPC_JAL: begin
                dec_raw.extop   = EXT_J;
                dec_raw.aluactr = 1'b1;
                dec_raw.alubctr = BSEL_FOUR;
                dec_raw.branch  = BR_JAL;
                dec_raw.regwr   = 1'b1;
                use_rd          = 1'b1;
            end
            OPC_JALR: begin
                // ALU produces the link value; EXU forms the target from rs1 + imm.
                dec_raw.extop   = EXT_I;
                dec_raw.aluactr = 1'b1;
                dec_raw.alubctr = BSEL_FOUR;
                dec_raw.branch  = BR_JALR;
                dec_raw.regwr   = 1'b1;
                use_rd          = 1'b1;
                use_rs1         = 1'b1;
                ill_raw         = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec_raw.extop   = EXT_B;
                dec_raw.branch  = BR_COND;
                dec_raw.aluctr  = ALU_SUB;
                dec_raw.alubctr = BSEL_RS2;
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
                ill_raw         = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LOAD: begin
                dec_raw.extop   = EXT_I;
                dec_raw.alubctr = BSEL_IMM;
                dec_raw.memrd   = 1'b1;
                dec_raw.regwr   = 1'b1;
                use_rd          = 1'b1;
                use_rs1         = 1'b1;
                ill_raw         = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                dec_raw.extop   = EXT_S;
                dec_raw.alubctr = BSEL_IMM;
                dec_raw.memwr   = 1'b1;
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
                ill_raw         = (f3 >= 3'b011);
            end
            OPC_OPIMM: begin
                dec_raw.extop   = EXT_I;
                dec_raw.alubctr = BSEL_IMM;
                dec_raw.aluctr  = {1'b0, f3};
                dec_raw.regwr   = 1'b1;
                use_rd          = 1'b1;
                use_rs1         = 1'b1;
                if (f3 == 3'b001) begin
                    ill_raw = (f7 != F7_ZERO);
                end else if (f3 == 3'b101) begin
                    if (f7 == F7_ALT) begin
                        dec_raw.aluctr = ALU_SRA;
                    end else if (f7 != F7_ZERO) begin
                        ill_raw = 1'b1;
                    end
                end
            end
            OPC_OP: begin
                dec_raw.alubctr = BSEL_RS2;
                dec_raw.aluctr  = {f7[5], f3};
                dec_raw.regwr   = 1'b1;
                use_rd          = 1'b1;
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
                imm_en          = 1'b0;
                ill_raw = !((f7 == F7_ZERO) ||
                            ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OPC_SYSTEM: begin
                dec_raw.extop = EXT_I;
                if (f3 == 3'b000) begin
                    if (in_inst == INST_EBREAK) begin
                        dec_raw.trap = 1'b1;
                    end else begin
                        ill_raw = 1'b1;
                    end
                end else if (EN_ZICSR && (f3 != 3'b100)) begin
                    // csrr*i carry a zero-extended immediate in the rs1 slot, not a register.
                    dec_raw.alubctr = BSEL_IMM;
                    dec_raw.regwr   = 1'b1;
                    use_rd          = 1'b1;
                    use_rs1         = ~f3[2];
                end else begin
                    ill_raw = 1'b1;
                end
            end
            default: begin
                ill_raw = 1'b1;
                imm_en  = 1'b0;
            end
        endcase
    end

    always_comb begin
        imm32 = '0;
        case (dec_raw.extop)
            EXT_I:   imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            EXT_U:   imm32 = {in_inst[31:12], 12'b0};
            EXT_S:   imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            EXT_B:   imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                              in_inst[30:25], in_inst[11:8], 1'b0};
            EXT_J:   imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                              in_inst[20], in_inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm_ext = XLEN'($signed(imm32));
    end

    // Final bundle: zero unused indices, range-check used ones, neutralise illegal controls.
    always_comb begin
        logic ill;
        dec     = dec_raw;
        dec.imm = imm_en ? imm_ext : '0;
        dec.rd  = use_rd  ? rd_f  : 5'd0;
        dec.rs1 = use_rs1 ? rs1_f : 5'd0;
        dec.rs2 = use_rs2 ? rs2_f : 5'd0;
        ill = ill_raw || (in_inst[1:0] != 2'b11)
            || (use_rd  && !reg_ok(rd_f))
            || (use_rs1 && !reg_ok(rs1_f))
            || (use_rs2 && !reg_ok(rs2_f));
        if (ill) begin
            dec.regwr  = 1'b0;
            dec.memrd  = 1'b0;
            dec.memwr  = 1'b0;
            dec.branch = BR_NONE;
            dec.trap   = 1'b0;
        end
        if (dec.rd == 5'd0) begin
            dec.regwr = 1'b0;
        end
        dec.illegal = ill;
    end

    logic accept, retire, go_halt;

    assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready && !flush;
    assign retire   = out_valid_q && out_ready;
    // A flush in the retire cycle cancels the EBREAK, so no halt.
    assign go_halt  = (state_q == ST_RUN) && retire && bundle_q.trap && !flush;

    always_comb begin
        state_d     = go_halt ? ST_HALT : state_q;
        bundle_d    = bundle_q;
        out_valid_d = out_valid_q;
        if (flush || go_halt) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
        end else if (retire) begin
            out_valid_d = 1'b0;
        end
        if (accept && !go_halt) begin
            bundle_d = dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign halted      = (state_q == ST_HALT);
    assign out_pc      = bundle_q.pc;
    assign out_rd      = bundle_q.rd;
    assign out_rs1     = bundle_q.rs1;
    assign out_rs2     = bundle_q.rs2;
    assign out_imm     = bundle_q.imm;
    assign out_Regwr   = bundle_q.regwr;
    assign out_Aluctr  = bundle_q.aluctr;
    assign out_Extop   = bundle_q.extop;
    assign out_AluActr = bundle_q.aluactr;
    assign out_AluBctr = bundle_q.alubctr;
    assign out_Branch  = bundle_q.branch;
    assign out_funct3  = bundle_q.funct3;
    assign out_memrd   = bundle_q.memrd;
    assign out_memwr   = bundle_q.memwr;
    assign out_illegal = bundle_q.illegal;
    assign out_trap    = bundle_q.trap;

endmodule
